life_gen_sequencer: RTL and testbench

Generation scheduler for the Game-of-Life board. It owns two board banks: a front bank that the VGA pixel path reads, and a back bank that it writes. It computes the next generation one cell per clock into the back bank, then swaps banks only at a vertical-blank boundary, so the display never shows a partially updated board. It sits between the VGA sync block (frame timing) and the pixel colouring logic (cell lookup).

---
 rtl/life_pkg.sv | 17 +
 rtl/life_cell_rule.sv | 21 ++
 rtl/life_gen_sequencer.sv | 153 +++++++++++++++
 tb/tb_life_gen_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and default geometry for the Game-of-Life generation engine.
package life_pkg;
    localparam int DEF_BIT_W   = 3;
    localparam int DEF_BIT_H   = 3;
    localparam int DEF_BOARD_W = 2 ** DEF_BIT_W;
    localparam int DEF_SIZE    = 2 ** (DEF_BIT_W + DEF_BIT_H);
    localparam int DEF_ADDR_W  = DEF_BIT_W + DEF_BIT_H;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SWAP_WAIT
    } state_t;

    // Live neighbour count, 0..8.
    typedef logic [3:0] nbr_cnt_t;
endpackage

// File: rtl/life_cell_rule.sv
// Next-state rule for one cell. Neighbours flagged invalid lie off the
// board and are treated as dead.
module life_cell_rule
    import life_pkg::*;
(
    input  logic       centre,
    input  logic [7:0] nbr,
    input  logic [7:0] nbr_vld,
    output logic       next
);
    nbr_cnt_t cnt;

    // Count live in-board neighbours.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++)
            cnt = cnt + nbr_cnt_t'(nbr[i] & nbr_vld[i]);
    end

    assign next = (cnt == 4'd3) || (centre && (cnt == 4'd2));
endmodule

// File: rtl/life_gen_sequencer.sv
// Double-buffered generation scheduler: computes the next board one cell per
// clock into the back bank and swaps banks only on vertical blank.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int BIT_W          = DEF_BIT_W,
    parameter int BIT_H          = DEF_BIT_H,
    parameter int FRAMES_PER_GEN = 60,
    localparam int ADDR_W        = BIT_W + BIT_H,
    localparam int SIZE          = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync_start,
    input  logic              run,
    input  logic              step,
    input  logic              seed_load,
    input  logic [SIZE-1:0]   seed_data,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_cell,
    output logic              busy,
    output logic              gen_done,
    output logic [15:0]       gen_count
);
    localparam int FC_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    state_t            state, state_nxt;
    logic [SIZE-1:0]   bank0, bank1, front;
    logic              front_sel;
    logic [FC_W-1:0]   frame_cnt;
    logic [ADDR_W-1:0] idx;
    logic              frame_last, scan_en, swap, frame_inc, frame_clr;
    logic [BIT_H-1:0]  row;
    logic [BIT_W-1:0]  col;
    logic [7:0]        nbr, nbr_vld;
    logic              cell_next;

    assign front      = front_sel ? bank1 : bank0;
    assign disp_cell  = front[disp_addr];
    assign busy       = (state != IDLE);
    assign frame_last = (frame_cnt == FC_W'(FRAMES_PER_GEN - 1));
    assign row        = idx[ADDR_W-1:BIT_W];
    assign col        = idx[BIT_W-1:0];

    // Gather the 8 neighbours of the scan cell; off-board ones are masked.
    always_comb begin
        logic [BIT_H-1:0] nr;
        logic [BIT_W-1:0] nc;
        int               k;
        nbr     = '0;
        nbr_vld = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    k  = (dr + 1) * 3 + (dc + 1);
                    k  = (k > 4) ? k - 1 : k;
                    nr = row + BIT_H'(dr);
                    nc = col + BIT_W'(dc);
                    nbr[k]     = front[{nr, nc}];
                    nbr_vld[k] = !((dr == -1 && row == '0) || (dr == 1 && row == '1) ||
                                   (dc == -1 && col == '0) || (dc == 1 && col == '1));
                end
            end
        end
    end

    life_cell_rule u_rule (
        .centre  (front[idx]),
        .nbr     (nbr),
        .nbr_vld (nbr_vld),
        .next    (cell_next)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and datapath controls; seed_load overrides everything.
    always_comb begin
        state_nxt = state;
        scan_en   = 1'b0;
        swap      = 1'b0;
        frame_inc = 1'b0;
        frame_clr = 1'b0;
        if (seed_load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run && vsync_start) begin
                        if (frame_last) frame_clr = 1'b1;
                        else            frame_inc = 1'b1;
                    end
                    if (step || (run && vsync_start && frame_last))
                        state_nxt = SCAN;
                end
                SCAN: begin
                    scan_en = 1'b1;
                    if (idx == '1) state_nxt = SWAP_WAIT;
                end
                SWAP_WAIT: begin
                    if (vsync_start) begin
                        swap      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters, scan index, front select and the swap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            idx       <= '0;
            front_sel <= 1'b0;
            gen_count <= '0;
            gen_done  <= 1'b0;
        end else begin
            gen_done <= swap;
            if (seed_load) begin
                frame_cnt <= '0;
                gen_count <= '0;
                idx       <= '0;
            end else begin
                if (frame_clr)      frame_cnt <= '0;
                else if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
                if (scan_en) idx <= idx + 1'b1;
                if (swap) begin
                    front_sel <= ~front_sel;
                    gen_count <= gen_count + 16'd1;
                end
            end
        end
    end

    // Bank writes: seed goes to the front bank, scan results to the back bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank0 <= '0;
            bank1 <= '0;
        end else if (seed_load) begin
            if (front_sel) bank1 <= seed_data;
            else           bank0 <= seed_data;
        end else if (scan_en) begin
            if (front_sel) bank0[idx] <= cell_next;
            else           bank1[idx] <= cell_next;
        end
    end
endmodule

// File: tb/tb_life_gen_sequencer.sv
`timescale 1ns/10ps
module tb_life_gen_sequencer;
    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        reset, vsync_start, run, step, seed_load;
    logic [63:0] seed_data;
    logic [5:0]  disp_addr;
    logic        disp_cell, busy, gen_done;
    logic [15:0] gen_count;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    life_gen_sequencer #(.BIT_W(3), .BIT_H(3), .FRAMES_PER_GEN(60)) dut (
        .clk(clk), .reset(reset), .vsync_start(vsync_start), .run(run),
        .step(step), .seed_load(seed_load), .seed_data(seed_data),
        .disp_addr(disp_addr), .disp_cell(disp_cell), .busy(busy),
        .gen_done(gen_done), .gen_count(gen_count)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) if (gen_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: next board from the rules, edges dead.
    function automatic logic [63:0] life_next(input logic [63:0] b);
        logic [63:0] r;
        int cnt, rr, cc;
        r = '0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        rr = y + dy;
                        cc = x + dx;
                        if (!(dy == 0 && dx == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            cnt += int'(b[rr*8+cc]);
                    end
                r[y*8+x] = (cnt == 3) || (b[y*8+x] && cnt == 2);
            end
        return r;
    endfunction

    task automatic read_front(output logic [63:0] v);
        for (int i = 0; i < 64; i++) begin
            disp_addr = 6'(i);
            #0.01;
            v[i] = disp_cell;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_step();
        step = 1'b1; @(negedge clk); step = 1'b0;
    endtask

    task automatic do_vs();
        vsync_start = 1'b1; @(negedge clk); vsync_start = 1'b0;
    endtask

    task automatic do_seed(input logic [63:0] s);
        seed_data = s; seed_load = 1'b1; @(negedge clk); seed_load = 1'b0;
    endtask

    initial begin
        logic [63:0] s, exp, fr, mf;
        int mg, d0, a, gens;
        reset = 1'b1; vsync_start = 0; run = 0; step = 0; seed_load = 0;
        seed_data = '0; disp_addr = '0;
        tick(2);
        reset = 1'b0;
        tick(2);

        // Reset state
        read_front(fr);
        chk("reset_front", fr, 64'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_gen_count", gen_count, 16'd0);
        chk("reset_gen_done", gen_done, 1'b0);
        tick(3);
        chk("reset_no_done_pulse", done_cnt, 0);

        // Blinker
        s = '0; s[10] = 1; s[11] = 1; s[12] = 1;
        do_seed(s);
        read_front(fr);
        chk("seed_front", fr, s);
        do_step();
        chk("step_busy", busy, 1'b1);
        tick(63);
        d0 = done_cnt;
        do_vs();                       // last SCAN cycle: ignored
        tick(1);
        chk("vs_in_scan_busy", busy, 1'b1);
        chk("vs_in_scan_no_done", done_cnt, d0);
        read_front(fr);
        chk("front_stable_swapwait", fr, s);
        do_vs();
        exp = '0; exp[3] = 1; exp[11] = 1; exp[19] = 1;
        read_front(fr);
        chk("blinker_gen1", fr, exp);
        chk("blinker_gen_count1", gen_count, 16'd1);
        chk("blinker_gen_done", gen_done, 1'b1);
        chk("blinker_busy_off", busy, 1'b0);
        tick(1);
        chk("gen_done_one_cycle", gen_done, 1'b0);
        chk("one_done_pulse", done_cnt, d0 + 1);
        do_step(); tick(64); do_vs();
        read_front(fr);
        chk("blinker_gen2", fr, s);
        chk("blinker_gen_count2", gen_count, 16'd2);

        // Corner: off-board cells are dead
        s = '0; s[0] = 1; s[1] = 1; s[8] = 1;
        do_seed(s);
        chk("seed_clears_count", gen_count, 16'd0);
        do_step(); tick(64); do_vs();
        exp = s; exp[9] = 1;
        read_front(fr);
        chk("corner_block", fr, exp);

        // Free-running: 60 counted vsyncs per generation, run=0 holds count
        s = {$urandom, $urandom};
        do_seed(s);
        run = 1'b1;
        for (int i = 0; i < 30; i++) begin do_vs(); tick(2); chk("run_wait_a", busy, 1'b0); end
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin do_vs(); tick(2); chk("run_hold", busy, 1'b0); end
        run = 1'b1;
        for (int i = 0; i < 29; i++) begin do_vs(); tick(2); chk("run_wait_b", busy, 1'b0); end
        do_vs();
        chk("run_60th_busy", busy, 1'b1);
        run = 1'b0;                    // drop mid-generation; still completes
        tick(63); do_vs(); do_vs();
        read_front(fr);
        chk("run_gen", fr, life_next(s));
        chk("run_gen_count", gen_count, 16'd1);

        // Seed during SCAN with simultaneous step
        do_step(); tick(20);
        d0 = done_cnt;
        s = '0; s[5] = 1;
        seed_data = s; seed_load = 1'b1; step = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; step = 1'b0;
        chk("midscan_seed_idle", busy, 1'b0);
        read_front(fr);
        chk("midscan_seed_front", fr, s);
        chk("midscan_seed_count", gen_count, 16'd0);
        tick(3);
        chk("midscan_seed_no_done", done_cnt, d0);
        chk("seed_step_dropped", busy, 1'b0);

        // Mid-scan seed restarts cleanly at cell 0
        do_step(); tick(37);
        s = {$urandom, $urandom};
        do_seed(s);
        do_step(); tick(64); do_vs();
        read_front(fr);
        chk("after_midscan_gen", fr, life_next(s));

        // Randomized generations vs. reference model
        for (int it = 0; it < 6; it++) begin
            mf = {$urandom, $urandom};
            mg = 0;
            do_seed(mf);
            gens = $urandom_range(1, 3);
            for (int g = 0; g < gens; g++) begin
                do_step();
                a = $urandom_range(0, 60);
                tick(a);
                do_vs();               // ignored in SCAN
                do_step();             // ignored in SCAN
                tick(62 - a);
                tick($urandom_range(0, 5));
                chk("rnd_swapwait_busy", busy, 1'b1);
                read_front(fr);
                chk("rnd_front_before_swap", fr, mf);
                do_vs();
                mf = life_next(mf);
                mg++;
                read_front(fr);
                chk("rnd_front", fr, mf);
                chk("rnd_gen_count", gen_count, 16'(mg));
                chk("rnd_gen_done", gen_done, 1'b1);
            end
        end

        // Asynchronous reset in SWAP_WAIT with the clock stopped
        s = {$urandom, $urandom} | 64'd1;
        do_seed(s);
        do_step(); tick(64);
        chk("pre_reset_busy", busy, 1'b1);
        clk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_count", gen_count, 16'd0);
        read_front(fr);
        chk("async_reset_front", fr, 64'd0);
        reset = 1'b0;
        #1 clk_en = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        do_vs();
        tick(2);
        chk("post_reset_no_swap", done_cnt, d0);
        chk("post_reset_count", gen_count, 16'd0);
        chk("post_reset_busy", busy, 1'b0);
        read_front(fr);
        chk("post_reset_front", fr, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
